// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the cpu_mc multi-cycle core: opcodes, FSM state
// encoding and instruction field layout.
package cpu_mc_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned REG_FIELD_W = 4;
  localparam int unsigned IMM_W       = 16;

  // Instruction field bit positions (LSB of each field)
  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 12;
  localparam int unsigned IMM_LSB = 16;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h7;
  localparam logic [OP_W-1:0] OP_LD   = 4'h8;
  localparam logic [OP_W-1:0] OP_ST   = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OP_W-1:0] OP_JC   = 4'hC;
  localparam logic [OP_W-1:0] OP_HALT = 4'hD;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_mc_regfile.sv
// General register file: NREGS x DATA_W, two combinational read ports, one
// synchronous write port. Indices >= NREGS read as 0 and writes to them are
// dropped, so 4-bit register fields are safe for any NREGS.
// Ports: clk, rst (sync active-low), ra/rb -> rda/rdb read ports,
//        we/wa/wd write port, r0_low = r0[7:0] for the LED glue.
module cpu_mc_regfile
  import cpu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_FIELD_W-1:0] ra,
  input  logic [REG_FIELD_W-1:0] rb,
  output logic [DATA_W-1:0]      rda,
  output logic [DATA_W-1:0]      rdb,
  input  logic                   we,
  input  logic [REG_FIELD_W-1:0] wa,
  input  logic [DATA_W-1:0]      wd,
  output logic [7:0]             r0_low
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (32'(wa) < NREGS)) begin
      regs[wa[IDX_W-1:0]] <= wd;
    end
  end

  assign rda    = (32'(ra) < NREGS) ? regs[ra[IDX_W-1:0]] : '0;
  assign rdb    = (32'(rb) < NREGS) ? regs[rb[IDX_W-1:0]] : '0;
  assign r0_low = regs[0][7:0];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle CPU top: FETCH/EXEC/MEM_REQ/MEM_WAIT/HALT sequencer with
// request/ready handshakes on the instruction and data ports, ALU, flags,
// and LED glue.
// Ports: prog_addr/instr_req/instr/instr_ready instruction port;
//        mem_addr/mem_wdata/mem_rdata/mem_read/mem_write/mem_busy/mem_ready
//        data port; halted status; reg_leds = r0[7:0]; pc_leds = PC[3:0].
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  prog_addr,
  output logic               instr_req,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic               mem_busy,
  input  logic               mem_ready,
  output logic               halted,
  output logic [7:0]         reg_leds,
  output logic [3:0]         pc_leds
);

  state_t state, next_state;

  logic [INSTR_W-1:0]     ir;
  logic [ADDR_W-1:0]      pc, pc_next, pc_inc, imm_a, ea;
  logic                   flag_z, flag_c;
  logic [OP_W-1:0]        op;
  logic [REG_FIELD_W-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0]      rs1_val, rs2_val, imm_d, alu_res, wd;
  logic [DATA_W:0]        sum;
  logic                   alu_c, is_alu, we;
  logic                   latch_ir, exec_en, mem_done, is_mem;

  // Instruction decode from the latched word
  assign op     = ir[OP_LSB +: OP_W];
  assign rd     = ir[RD_LSB +: REG_FIELD_W];
  assign rs1    = ir[RS1_LSB +: REG_FIELD_W];
  assign rs2    = ir[RS2_LSB +: REG_FIELD_W];
  assign imm_d  = DATA_W'(ir[IMM_LSB +: IMM_W]);
  assign imm_a  = ADDR_W'(ir[IMM_LSB +: IMM_W]);
  assign pc_inc = pc + ADDR_W'(1);
  assign ea     = ADDR_W'(rs1_val) + imm_a;
  assign is_mem = (op == OP_LD) || (op == OP_ST);

  cpu_mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .ra     (rs1),
    .rb     (rs2),
    .rda    (rs1_val),
    .rdb    (rs2_val),
    .we     (we),
    .wa     (rd),
    .wd     (wd),
    .r0_low (reg_leds)
  );

  // ALU; is_alu marks the ops that update flags. SUB is rs1 + ~rs2 + 1.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    is_alu  = 1'b1;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, rs1_val} + {1'b0, rs2_val};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        sum     = {1'b0, rs1_val} + {1'b0, ~rs2_val} + (DATA_W+1)'(1);
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_ADDI: begin
        sum     = {1'b0, rs1_val} + {1'b0, imm_d};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_AND:  alu_res = rs1_val & rs2_val;
      OP_OR:   alu_res = rs1_val | rs2_val;
      OP_XOR:  alu_res = rs1_val ^ rs2_val;
      default: is_alu = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // Next state, handshake outputs and datapath enables
  always_comb begin
    next_state = state;
    instr_req  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    halted     = 1'b0;
    latch_ir   = 1'b0;
    exec_en    = 1'b0;
    mem_done   = 1'b0;
    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          latch_ir   = 1'b1;
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (is_mem)               next_state = S_MEM_REQ;
        else if (op == OP_HALT)   next_state = S_HALT;
        else                      next_state = S_FETCH;
      end
      S_MEM_REQ: begin
        if (!mem_busy) begin
          mem_read   = (op == OP_LD);
          mem_write  = (op == OP_ST);
          next_state = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          mem_done   = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      default: next_state = S_FETCH;
    endcase
  end

  // PC update and register write selection
  always_comb begin
    pc_next = pc;
    we      = 1'b0;
    wd      = alu_res;
    if (exec_en) begin
      case (op)
        OP_LD, OP_ST, OP_HALT: pc_next = pc;
        OP_JMP: pc_next = imm_a;
        OP_JZ:  pc_next = flag_z ? imm_a : pc_inc;
        OP_JC:  pc_next = flag_c ? imm_a : pc_inc;
        OP_LDI: begin
          we      = 1'b1;
          wd      = imm_d;
          pc_next = pc_inc;
        end
        default: begin
          we      = is_alu;
          pc_next = pc_inc;
        end
      endcase
    end
    if (mem_done) begin
      pc_next = pc_inc;
      we      = (op == OP_LD);
      wd      = mem_rdata;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= '0;
      ir        <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      pc <= pc_next;
      if (latch_ir) ir <= instr;
      if (exec_en && is_alu) begin
        flag_z <= (alu_res == '0);
        flag_c <= alu_c;
      end
      if (exec_en && is_mem) mem_addr <= ea;
      if (exec_en && (op == OP_ST)) mem_wdata <= rs2_val;
    end
  end

  assign prog_addr = pc;
  assign pc_leds   = pc[3:0];

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc. Two instances (16-bit/8 regs and 32-bit/4 regs)
// share all inputs and run in lockstep; each scenario checks the instance it
// targets. Inputs change and outputs are sampled on the falling edge.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready = 1'b0;
  logic        mem_busy = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] rdata32 = '0;

  logic [15:0] prog_addr_a, mem_addr_a, mem_wdata_a;
  logic        instr_req_a, mem_read_a, mem_write_a, halted_a;
  logic [7:0]  reg_leds_a;
  logic [3:0]  pc_leds_a;

  logic [15:0] prog_addr_b, mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic        instr_req_b, mem_read_b, mem_write_b, halted_b;
  logic [7:0]  reg_leds_b;
  logic [3:0]  pc_leds_b;

  int checks = 0;
  int errors = 0;

  logic        obs_we_a;
  logic [15:0] obs_addr_a, obs_data_a, obs_addr_b;
  logic [31:0] obs_data_b;

  always #5 clk = ~clk;

  cpu_mc u_a (
    .clk(clk), .rst(rst), .prog_addr(prog_addr_a), .instr_req(instr_req_a),
    .instr(instr), .instr_ready(instr_ready), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(rdata32[15:0]), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_busy(mem_busy), .mem_ready(mem_ready),
    .halted(halted_a), .reg_leds(reg_leds_a), .pc_leds(pc_leds_a)
  );

  cpu_mc #(.DATA_W(32), .NREGS(4), .ADDR_W(16)) u_b (
    .clk(clk), .rst(rst), .prog_addr(prog_addr_b), .instr_req(instr_req_b),
    .instr(instr), .instr_ready(instr_ready), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(rdata32), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_busy(mem_busy), .mem_ready(mem_ready),
    .halted(halted_b), .reg_leds(reg_leds_b), .pc_leds(pc_leds_b)
  );

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {imm, rs2, rs1, rd, op};
  endfunction

  // Wait (bounded) for instr_req, then present w after 'delay' cycles; returns in EXEC.
  task automatic fetch(input logic [31:0] w, input int delay);
    int n = 0;
    while (!instr_req_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_req_a) begin
      errors++;
      $display("FAIL fetch_timeout instr_req=%b required 1", instr_req_a);
    end
    repeat (delay) @(negedge clk);
    instr = w;
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    instr = '0;
  endtask

  // Fetch and execute a non-memory instruction.
  task automatic run(input logic [31:0] w);
    fetch(w, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ST rs2,[r15+addr] (r15 reads 0) and capture the strobe-cycle outputs.
  task automatic store_obs(input logic [3:0] rs2, input logic [15:0] addr);
    fetch(enc(4'h9, 4'h0, 4'hF, rs2, addr), 0);
    @(posedge clk);
    @(negedge clk);
    obs_we_a   = mem_write_a;
    obs_addr_a = mem_addr_a;
    obs_data_a = mem_wdata_a;
    obs_addr_b = mem_addr_b;
    obs_data_b = mem_wdata_b;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (prog_addr_a !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", prog_addr_a); end
    checks++; if ({mem_read_a, mem_write_a, halted_a} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {mem_read_a, mem_write_a, halted_a}); end
    checks++; if ({mem_addr_a, mem_wdata_a} !== 32'h0) begin errors++; $display("FAIL reset_mem_regs got %h want 0", {mem_addr_a, mem_wdata_a}); end
    checks++; if (reg_leds_a !== 8'h0 || pc_leds_a !== 4'h0) begin errors++; $display("FAIL reset_leds got %h/%h want 00/0", reg_leds_a, pc_leds_a); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (instr_req_a !== 1'b1) begin errors++; $display("FAIL reset_instr_req got %b want 1", instr_req_a); end
  endtask

  task automatic test_alu();
    repeat (2) @(negedge clk);
    checks++; if (instr_req_a !== 1'b1 || prog_addr_a !== 16'h0) begin errors++; $display("FAIL fetch_stall got req=%b pc=%h want 1/0000", instr_req_a, prog_addr_a); end
    fetch(enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h1234), 0);
    checks++; if (instr_req_a !== 1'b0) begin errors++; $display("FAIL exec_req got %b want 0", instr_req_a); end
    @(posedge clk); @(negedge clk);
    run(enc(4'h7, 4'd2, 4'd1, 4'd0, 16'h0001));
    run(enc(4'hB, 4'd0, 4'd0, 4'd0, 16'h0040));
    checks++; if (prog_addr_a !== 16'h0003) begin errors++; $display("FAIL jz_untaken got %h want 0003", prog_addr_a); end
    store_obs(4'd2, 16'h0100);
    checks++; if (obs_we_a !== 1'b1 || obs_addr_a !== 16'h0100) begin errors++; $display("FAIL st_addr got we=%b addr=%h want 1/0100", obs_we_a, obs_addr_a); end
    checks++; if (obs_data_a !== 16'h1235) begin errors++; $display("FAIL addi_r2 got %h want 1235", obs_data_a); end
    checks++; if (prog_addr_a !== 16'h0004) begin errors++; $display("FAIL st_pc got %h want 0004", prog_addr_a); end
  endtask

  task automatic test_branch();
    run(enc(4'h3, 4'd3, 4'd1, 4'd1, 16'h0));
    run(enc(4'hB, 4'd0, 4'd0, 4'd0, 16'h0010));
    checks++; if (prog_addr_a !== 16'h0010) begin errors++; $display("FAIL jz_taken got %h want 0010", prog_addr_a); end
    store_obs(4'd3, 16'h0104);
    checks++; if (obs_data_a !== 16'h0000) begin errors++; $display("FAIL sub_r3 got %h want 0000", obs_data_a); end
    run(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0030));
    checks++; if (prog_addr_a !== 16'h0030) begin errors++; $display("FAIL jc_after_sub got %h want 0030", prog_addr_a); end
    run(enc(4'h5, 4'd3, 4'd1, 4'd1, 16'h0));
    run(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0060));
    checks++; if (prog_addr_a !== 16'h0032) begin errors++; $display("FAIL jc_untaken got %h want 0032", prog_addr_a); end
  endtask

  task automatic test_carry();
    run(enc(4'h1, 4'd4, 4'd0, 4'd0, 16'hFFFF));
    run(enc(4'h1, 4'd5, 4'd0, 4'd0, 16'h0001));
    run(enc(4'h2, 4'd6, 4'd4, 4'd5, 16'h0));
    run(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0020));
    checks++; if (prog_addr_a !== 16'h0020) begin errors++; $display("FAIL add_carry_jc got %h want 0020", prog_addr_a); end
    run(enc(4'hB, 4'd0, 4'd0, 4'd0, 16'h0070));
    checks++; if (prog_addr_a !== 16'h0070) begin errors++; $display("FAIL add_zero_jz got %h want 0070", prog_addr_a); end
    run(enc(4'h4, 4'd0, 4'd4, 4'd5, 16'h0));
    checks++; if (reg_leds_a !== 8'h01) begin errors++; $display("FAIL and_r0_leds got %h want 01", reg_leds_a); end
    run(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0090));
    checks++; if (prog_addr_a !== 16'h0072) begin errors++; $display("FAIL and_clears_c got %h want 0072", prog_addr_a); end
    run(enc(4'hB, 4'd0, 4'd0, 4'd0, 16'h0090));
    checks++; if (prog_addr_a !== 16'h0073) begin errors++; $display("FAIL and_clears_z got %h want 0073", prog_addr_a); end
    store_obs(4'd6, 16'h0108);
    checks++; if (obs_data_a !== 16'h0000) begin errors++; $display("FAIL add_r6 got %h want 0000", obs_data_a); end
  endtask

  task automatic test_mem();
    int reads = 0;
    int early = 0;
    // ST r1,[r2+2] with busy held for three cycles
    fetch(enc(4'h9, 4'd0, 4'd2, 4'd1, 16'h0002), 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      if (mem_write_a !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL st_busy_strobe got %0d early strobes want 0", early); end
    mem_busy = 1'b0;
    #1;
    checks++; if (mem_write_a !== 1'b1 || mem_read_a !== 1'b0) begin errors++; $display("FAIL st_strobe got w=%b r=%b want 1/0", mem_write_a, mem_read_a); end
    checks++; if (mem_addr_a !== 16'h1237 || mem_wdata_a !== 16'h1234) begin errors++; $display("FAIL st_payload got %h/%h want 1237/1234", mem_addr_a, mem_wdata_a); end
    @(posedge clk); @(negedge clk);
    checks++; if (mem_write_a !== 1'b0) begin errors++; $display("FAIL st_one_cycle got %b want 0", mem_write_a); end
    mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (prog_addr_a !== 16'h0075 || pc_leds_a !== 4'h5) begin errors++; $display("FAIL st_done_pc got %h/%h want 0075/5", prog_addr_a, pc_leds_a); end
    // LD r7,[r2+2]; stray ready with the strobe, real ready 5 cycles later
    early = 0;
    fetch(enc(4'h8, 4'd7, 4'd2, 4'd0, 16'h0002), 0);
    @(posedge clk); @(negedge clk);
    if (mem_read_a === 1'b1) reads++;
    checks++; if (mem_addr_a !== 16'h1237) begin errors++; $display("FAIL ld_addr got %h want 1237", mem_addr_a); end
    mem_ready = 1'b1;
    rdata32 = 32'h0000BEEF;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_read_a === 1'b1) reads++;
      if (instr_req_a !== 1'b0) early++;
      @(posedge clk); @(negedge clk);
    end
    mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (reads != 1) begin errors++; $display("FAIL ld_read_pulses got %0d want 1", reads); end
    checks++; if (early != 0) begin errors++; $display("FAIL ld_stray_ready got %0d early fetch cycles want 0", early); end
    store_obs(4'd7, 16'h010C);
    checks++; if (obs_data_a !== 16'hBEEF) begin errors++; $display("FAIL ld_r7 got %h want beef", obs_data_a); end
  endtask

  task automatic test_reset_mid();
    fetch(enc(4'h8, 4'd0, 4'hF, 4'd0, 16'h0200), 0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({mem_read_a, mem_write_a} !== 2'b00) begin errors++; $display("FAIL rst_mid_strobes got %b want 00", {mem_read_a, mem_write_a}); end
    checks++; if (prog_addr_a !== 16'h0 || mem_addr_a !== 16'h0 || instr_req_a !== 1'b1) begin errors++; $display("FAIL rst_mid_state got pc=%h addr=%h req=%b want 0/0/1", prog_addr_a, mem_addr_a, instr_req_a); end
    rst = 1'b1;
    mem_ready = 1'b1;
    rdata32 = 32'h000000AA;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (reg_leds_a !== 8'h00 || instr_req_a !== 1'b1) begin errors++; $display("FAIL late_ready got leds=%h req=%b want 00/1", reg_leds_a, instr_req_a); end
    store_obs(4'd1, 16'h0000);
    checks++; if (obs_data_a !== 16'h0000) begin errors++; $display("FAIL rst_r1 got %h want 0000", obs_data_a); end
    store_obs(4'd7, 16'h0002);
    checks++; if (obs_data_a !== 16'h0000) begin errors++; $display("FAIL rst_r7 got %h want 0000", obs_data_a); end
  endtask

  task automatic test_wide();
    int bad = 0;
    run(enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0009));
    run(enc(4'h1, 4'd5, 4'd0, 4'd0, 16'h0007));
    run(enc(4'h2, 4'd1, 4'd5, 4'd5, 16'h0));
    store_obs(4'd1, 16'h0010);
    checks++; if (obs_data_b !== 32'h0 || obs_addr_b !== 16'h0010) begin errors++; $display("FAIL w_oob_reg got %h@%h want 00000000@0010", obs_data_b, obs_addr_b); end
    run(enc(4'h1, 4'd3, 4'd0, 4'd0, 16'h0001));
    run(enc(4'h3, 4'd2, 4'hF, 4'd3, 16'h0));
    store_obs(4'd2, 16'h0014);
    checks++; if (obs_data_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL w_sub got %h want ffffffff", obs_data_b); end
    run(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0040));
    checks++; if (prog_addr_b !== 16'h000A) begin errors++; $display("FAIL w_sub_borrow got %h want 000a", prog_addr_b); end
    run(enc(4'h7, 4'd2, 4'd2, 4'd0, 16'h0001));
    run(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0040));
    checks++; if (prog_addr_b !== 16'h0040 || pc_leds_b !== 4'h0) begin errors++; $display("FAIL w_addi_carry got %h/%h want 0040/0", prog_addr_b, pc_leds_b); end
    store_obs(4'd2, 16'h0018);
    checks++; if (obs_data_b !== 32'h0) begin errors++; $display("FAIL w_addi_wrap got %h want 00000000", obs_data_b); end
    fetch(enc(4'hD, 4'd0, 4'd0, 4'd0, 16'h0), 0);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (halted_b !== 1'b1 || instr_req_b !== 1'b0 || mem_read_b !== 1'b0 || mem_write_b !== 1'b0) bad++;
      instr_ready = (i == 5);
      mem_ready   = (i == 7);
      @(posedge clk); @(negedge clk);
    end
    instr_ready = 1'b0;
    mem_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL w_halt got %0d bad cycles want 0", bad); end
    checks++; if (halted_a !== 1'b1 || reg_leds_b !== 8'h00) begin errors++; $display("FAIL halt_a got halted=%b leds_b=%h want 1/00", halted_a, reg_leds_b); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_carry();
    test_mem();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
